// File: rtl/if_fetch_unit.sv
// IF stage: fetch PC, single-outstanding bus master, one-entry prefetch buffer,
// and the IF/ID register feeding the decoder. Handles branch redirects and flushes.
module if_fetch_unit #(
  parameter logic [29:0] RESET_VECTOR = 30'h0,
  parameter logic [31:0] NOP_INSN     = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [29:0] new_pc,
  input  logic        br_taken,
  input  logic [29:0] br_addr,
  output logic        bus_req_,
  input  logic        bus_grant_,
  output logic [29:0] bus_addr,
  output logic        bus_as_,
  output logic        bus_rw,
  output logic [31:0] bus_wr_data,
  input  logic [31:0] bus_rd_data,
  input  logic        bus_rdy_,
  output logic [29:0] if_pc,
  output logic [31:0] if_insn,
  output logic        if_en
);

  typedef enum logic [1:0] {IDLE, REQ, ACCESS, WAIT} state_t;

  state_t      state;
  logic [29:0] fetch_pc;
  logic [29:0] buf_pc;
  logic [31:0] buf_insn;
  logic        buf_vld;
  logic        discard;

  logic        consume;
  logic        redirect;
  logic [29:0] redir_pc;
  logic [29:0] pc_eff;
  logic        complete;
  logic        accept;

  // Flush wins over a branch and ignores stall; a redirect also kills a same-cycle completion.
  always_comb begin
    consume  = if_en & ~stall;
    redirect = flush | (consume & br_taken);
    redir_pc = flush ? new_pc : br_addr;
    pc_eff   = redirect ? redir_pc : fetch_pc;
    complete = (state == WAIT) & ~bus_rdy_;
    accept   = complete & ~discard & ~redirect;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      fetch_pc    <= RESET_VECTOR;
      buf_pc      <= '0;
      buf_insn    <= '0;
      buf_vld     <= 1'b0;
      discard     <= 1'b0;
      bus_req_    <= 1'b1;
      bus_as_     <= 1'b1;
      bus_addr    <= '0;
      bus_rw      <= 1'b1;
      bus_wr_data <= '0;
      if_pc       <= RESET_VECTOR;
      if_insn     <= NOP_INSN;
      if_en       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!buf_vld) begin
            state    <= REQ;
            bus_req_ <= 1'b0;
          end
        end
        REQ: begin
          // A redirect landing on the grant edge is fetched directly, no discard needed.
          if (!bus_grant_) begin
            state    <= ACCESS;
            bus_addr <= pc_eff;
            bus_as_  <= 1'b0;
          end
        end
        ACCESS: begin
          state   <= WAIT;
          bus_as_ <= 1'b1;
        end
        WAIT: begin
          if (!bus_rdy_) begin
            state    <= IDLE;
            bus_req_ <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (redirect)
        fetch_pc <= redir_pc;
      else if (accept)
        fetch_pc <= fetch_pc + 30'd1;

      if (complete)
        discard <= 1'b0;
      else if (redirect && (state == ACCESS || state == WAIT))
        discard <= 1'b1;

      // A completion can only coincide with an empty buffer: the FSM idles while it is full.
      if (redirect) begin
        if_en   <= 1'b0;
        if_insn <= NOP_INSN;
        buf_vld <= 1'b0;
      end else if (accept && (!if_en || consume)) begin
        if_pc   <= bus_addr;
        if_insn <= bus_rd_data;
        if_en   <= 1'b1;
      end else if (accept) begin
        buf_vld  <= 1'b1;
        buf_pc   <= bus_addr;
        buf_insn <= bus_rd_data;
      end else if (consume && buf_vld) begin
        if_pc   <= buf_pc;
        if_insn <= buf_insn;
        if_en   <= 1'b1;
        buf_vld <= 1'b0;
      end else if (consume) begin
        if_en   <= 1'b0;
        if_insn <= NOP_INSN;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: random bus slave and pipeline stimulus, checked against an
// instruction-stream model (expected next PC seen by ID, word = mem(PC)).
module tb_if_fetch_unit;

  localparam logic [29:0] RV  = 30'h10;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, flush, br_taken;
  logic [29:0] new_pc, br_addr;
  logic        bus_req_, bus_grant_, bus_as_, bus_rw, bus_rdy_;
  logic [29:0] bus_addr;
  logic [31:0] bus_wr_data, bus_rd_data;
  logic [29:0] if_pc;
  logic [31:0] if_insn;
  logic        if_en;

  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_VECTOR(RV), .NOP_INSN(NOP)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .new_pc(new_pc),
    .br_taken(br_taken), .br_addr(br_addr), .bus_req_(bus_req_), .bus_grant_(bus_grant_),
    .bus_addr(bus_addr), .bus_as_(bus_as_), .bus_rw(bus_rw), .bus_wr_data(bus_wr_data),
    .bus_rd_data(bus_rd_data), .bus_rdy_(bus_rdy_), .if_pc(if_pc), .if_insn(if_insn),
    .if_en(if_en)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem(input logic [29:0] a);
    return {a, 2'b01} ^ 32'h9E37_79B9 ^ {a[13:0], a[29:12]};
  endfunction

  function automatic logic [29:0] pick_pc();
    case ($urandom_range(0, 3))
      0:       return 30'h3FFF_FFFE;
      1:       return 30'h40;
      default: return 30'($urandom);
    endcase
  endfunction

  // stimulus knobs (percent) and slave latency
  int grant_pct, stall_pct, flush_pct, br_pct, rdy_max;

  // reference model: next PC the decoder must see as valid
  logic [29:0] exp_pc;
  bit          exp_bubble;
  int          gap;
  int          consumed;
  // bus slave
  bit          pend;
  int          cnt;
  logic [29:0] s_addr;
  logic        prev_as;

  task automatic cycle();
    logic c;
    @(negedge clk);
    chk("bus_rw", 64'(bus_rw), 64'd1);
    chk("bus_wr_data", 64'(bus_wr_data), 64'd0);
    if (!if_en) chk("nop_insn", 64'(if_insn), 64'(NOP));
    if (!bus_as_) begin
      chk("as_with_req", 64'(bus_req_), 64'd0);
      chk("as_one_cycle", 64'(prev_as), 64'd1);
    end
    if (exp_bubble) chk("bubble", 64'(if_en), 64'd0);
    exp_bubble = 1'b0;
    prev_as = bus_as_;

    if (pend && cnt == 0) begin
      bus_rdy_    = 1'b0;
      bus_rd_data = mem(s_addr);
      pend        = 1'b0;
    end else begin
      bus_rdy_    = 1'b1;
      bus_rd_data = $urandom;
      if (pend) cnt--;
    end
    if (!bus_as_) begin
      pend   = 1'b1;
      s_addr = bus_addr;
      cnt    = $urandom_range(0, rdy_max);
    end

    bus_grant_ = !($urandom_range(0, 99) < grant_pct);
    stall      = ($urandom_range(0, 99) < stall_pct);
    flush      = ($urandom_range(0, 99) < flush_pct);
    br_taken   = ($urandom_range(0, 99) < br_pct);
    new_pc     = pick_pc();
    br_addr    = pick_pc();

    c = if_en && !stall;
    if (flush) begin
      exp_pc     = new_pc;
      exp_bubble = 1'b1;
    end else if (c) begin
      chk("if_pc", 64'(if_pc), 64'(exp_pc));
      chk("if_insn", 64'(if_insn), 64'(mem(exp_pc)));
      consumed++;
      if (br_taken) begin
        exp_pc     = br_addr;
        exp_bubble = 1'b1;
      end else begin
        exp_pc = exp_pc + 30'd1;
      end
    end
    if (c && !flush) gap = 0;
    else gap++;
    if (gap > 120) begin
      chk("watchdog", 64'(gap), 64'd0);
      gap = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b0;
    bus_rdy_ = 1'b1;
    #1;
    chk("rst_bus_req_", 64'(bus_req_), 64'd1);
    chk("rst_bus_as_", 64'(bus_as_), 64'd1);
    chk("rst_bus_addr", 64'(bus_addr), 64'd0);
    chk("rst_bus_rw", 64'(bus_rw), 64'd1);
    chk("rst_wr_data", 64'(bus_wr_data), 64'd0);
    chk("rst_if_pc", 64'(if_pc), 64'(RV));
    chk("rst_if_insn", 64'(if_insn), 64'(NOP));
    chk("rst_if_en", 64'(if_en), 64'd0);
    repeat (2) @(negedge clk);
    bus_grant_ = 1'b1;
    stall = 1'b0; flush = 1'b0; br_taken = 1'b0;
    reset = 1'b1;
    exp_pc = RV; exp_bubble = 1'b0; gap = 0; prev_as = 1'b1;
  endtask

  initial begin
    int guard;
    int start_cnt;
    reset = 1'b1; stall = 1'b0; flush = 1'b0; br_taken = 1'b0;
    new_pc = '0; br_addr = '0; bus_grant_ = 1'b1; bus_rdy_ = 1'b1; bus_rd_data = '0;
    pend = 1'b0; cnt = 0; s_addr = '0; consumed = 0; prev_as = 1'b1;

    // first fetch with immediate grant and one-cycle ready
    grant_pct = 100; stall_pct = 0; flush_pct = 0; br_pct = 0; rdy_max = 0;
    do_reset();
    cycle();
    chk("t1_req", 64'(bus_req_), 64'd0);
    chk("t1_as_idle", 64'(bus_as_), 64'd1);
    cycle();
    chk("t1_as_low", 64'(bus_as_), 64'd0);
    chk("t1_addr", 64'(bus_addr), 64'(RV));
    cycle();
    chk("t1_as_high", 64'(bus_as_), 64'd1);
    chk("t1_en_wait", 64'(if_en), 64'd0);
    cycle();
    chk("t1_if_en", 64'(if_en), 64'd1);
    chk("t1_if_pc", 64'(if_pc), 64'(RV));
    chk("t1_if_insn", 64'(if_insn), 64'(mem(RV)));
    cycle();
    cycle();
    chk("t1_next_as", 64'(bus_as_), 64'd0);
    chk("t1_next_addr", 64'(bus_addr), 64'(RV + 30'd1));

    // random traffic, then heavy stall to exercise the prefetch buffer
    grant_pct = 60; stall_pct = 30; flush_pct = 4; br_pct = 15; rdy_max = 3;
    repeat (3000) cycle();
    stall_pct = 70;
    repeat (1000) cycle();
    chk("progress", 64'(consumed > 200), 64'd1);

    // reset while in WAIT, stale ready after release, grant withheld
    guard = 0;
    while (!pend && guard < 60) begin
      cycle();
      guard++;
    end
    chk("reach_wait", 64'(pend), 64'd1);
    cnt = 3;
    cycle();
    grant_pct = 0; stall_pct = 0; flush_pct = 0; br_pct = 0;
    do_reset();
    repeat (6) begin
      cycle();
      chk("t5_req", 64'(bus_req_), 64'd0);
      chk("t5_as", 64'(bus_as_), 64'd1);
      chk("t5_en", 64'(if_en), 64'd0);
    end
    grant_pct = 100;
    start_cnt = consumed;
    guard = 0;
    while (bus_as_ && guard < 20) begin
      cycle();
      guard++;
    end
    chk("t6_restart_addr", 64'(bus_addr), 64'(RV));
    guard = 0;
    while (consumed == start_cnt && guard < 20) begin
      cycle();
      guard++;
    end
    chk("t6_consumed", 64'(consumed > start_cnt), 64'd1);

    grant_pct = 50; stall_pct = 25; flush_pct = 3; br_pct = 20;
    repeat (1000) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
